mul3_prod_acc: RTL
==================

MUL3_PROD_ACC -- requirements
Module: mul3_prod_acc

Interface
REQ-001 Parameter N, default 4, legal 1..16: number of products summed per result.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clr  input  1  synchronous abort of the current accumulation.
REQ-005 prod  input  6  unsigned 3x3 product from the upstream multiplier, range 0..49.
REQ-006 prod_valid  input  1  prod is valid this cycle.
REQ-007 prod_ready  output  1  block accepts prod this cycle.
REQ-008 sum  output  10  unsigned sum of the last N accepted products.
REQ-009 sum_valid  output  1  sum holds a completed, unconsumed result.
REQ-010 sum_ready  input  1  downstream consumes sum this cycle.

Function
REQ-011 The block SHALL have two states: ACC (collecting) and DONE (result pending).
REQ-012 prod_ready SHALL be combinational: 1 when state==ACC and clr==0, else 0.
REQ-013 A product transfer SHALL occur exactly when prod_valid and prod_ready are both 1.
REQ-014 On a transfer with cnt<N-1: acc <= acc + zero-extended prod; cnt <= cnt+1; state stays ACC.
REQ-015 On a transfer with cnt==N-1: sum <= acc + prod; acc <= 0; cnt <= 0; state <= DONE.
REQ-016 Latency: sum_valid SHALL rise in the cycle after the Nth transfer.
REQ-017 sum_valid SHALL be 1 exactly when state==DONE.
REQ-018 In DONE, sum SHALL remain stable, and no product is accepted, until sum_ready==1.
REQ-019 DONE with sum_ready==1 SHALL return to ACC the next cycle; sum_valid then drops.
REQ-020 sum SHALL retain its last value after consumption, until the next result overwrites it.
REQ-021 prod_valid gaps SHALL NOT disturb acc or cnt.
REQ-022 clr==1 in any state SHALL set acc=0, cnt=0 and state=ACC next cycle; sum keeps its value.
REQ-023 clr SHALL override a simultaneous sum_ready or transfer; no product is lost, because prod_ready==0.
REQ-024 For N=1, every transfer SHALL go directly to DONE with sum=prod.
REQ-025 Arithmetic SHALL be unsigned, 10 bits wide, and cannot overflow (16*49=784<1024).

Reset
REQ-026 With rst high: state=ACC, acc=0, cnt=0, sum=0, sum_valid=0; prod_ready follows REQ-012.
REQ-027 Assertion of rst mid-accumulation or in DONE SHALL discard all partial and pending results immediately.
REQ-028 The first transfer after rst deassertion SHALL be counted as product 1 of N.

Structure
REQ-029 Shared package mul3_acc_pkg SHALL hold: PROD_W=6, ACC_W=10, CNT_W=4, and the state enum {ACC, DONE}.
REQ-030 One sub-module, acc_add10: combinational 10-bit unsigned adder (acc + zero-extended prod).
REQ-031 The FSM, counter and registers SHALL live in mul3_prod_acc; there are no other sub-modules.

Verification
REQ-032 N=4, prod=49 x4 back-to-back, sum_ready=1 -> sum=196, sum_valid high for 1 cycle, one cycle after the 4th transfer.
REQ-033 N=16, prod=49 x16 -> sum=784; then prod=0 x16 -> sum=0.
REQ-034 N=4, prod 1,2,3,4 with sum_ready=0 for 5 cycles -> sum=10, sum_valid held, prod_ready=0 for the whole time; sum_ready=1 -> prod_ready=1 next cycle.
REQ-035 N=4, prod 7,7 then clr=1 with prod_valid=1, then prod 1 x4 -> sum=4; the product offered during clr is not accepted.
REQ-036 N=4, 3 products accepted, then rst pulsed asynchronously mid-cycle -> all outputs at reset values; then prod 5 x4 -> sum=20.
REQ-037 N=1, prod 42 with prod_valid toggling 1/0 -> each transfer yields sum=42 with one sum_valid pulse.

Source files
------------

// File: rtl/mul3_acc_pkg.sv
// Shared widths and state encoding for the 3x3-product accumulator.
package mul3_acc_pkg;
    localparam int PROD_W = 6;
    localparam int ACC_W  = 10;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;
endpackage

// File: rtl/acc_add10.sv
// Combinational 10-bit unsigned adder: accumulator plus zero-extended product.
module acc_add10
    import mul3_acc_pkg::*;
(
    input  logic [ACC_W-1:0]  i_a,
    input  logic [PROD_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_sum
);
    assign o_sum = i_a + {{(ACC_W-PROD_W){1'b0}}, i_b};
endmodule

// File: rtl/mul3_prod_acc.sv
// Sums N products from a 3x3 multiplier and holds the result until consumed.
module mul3_prod_acc
    import mul3_acc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready
);
    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_sum;

    state_t             w_state_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ACC_W-1:0]   w_sum_nxt;
    logic [ACC_W-1:0]   w_add;
    logic               w_xfer;
    logic               w_last;

    acc_add10 u_add (
        .i_a   (r_acc),
        .i_b   (prod),
        .o_sum (w_add)
    );

    assign prod_ready = (r_state == ACC) && !clr;
    assign sum_valid  = (r_state == DONE);
    assign sum        = r_sum;
    assign w_xfer     = prod_valid && prod_ready;
    assign w_last     = (r_cnt == CNT_W'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        if (clr) begin
            // Abort wins over everything; sum keeps its last value.
            w_state_nxt = ACC;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ACC: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            w_sum_nxt   = w_add;
                            w_acc_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = DONE;
                        end else begin
                            w_acc_nxt = w_add;
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        w_state_nxt = ACC;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sum   <= w_sum_nxt;
        end
    end
endmodule
